// File: rtl/fetch_exec_control.sv
// Fetch/decode/execute sequencer for the 8-bit, 32-word accumulator datapath.
// In: Clock, Reset(n), Opcode, Aeq0, Apos, Enter. Out: datapath strobes, Halt, State.
module fetch_exec_control #(
  parameter int STATE_W    = 4,
  parameter int ENTER_SYNC = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [2:0]         Opcode,
  input  logic               Aeq0,
  input  logic               Apos,
  input  logic               Enter,
  output logic               IRload,
  output logic               PCload,
  output logic               JMPmux,
  output logic               Meminst,
  output logic               MemWr,
  output logic [1:0]         Asel,
  output logic               Aload,
  output logic               Sub,
  output logic               Halt,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    START  = STATE_W'(0),
    FETCH  = STATE_W'(1),
    DECODE = STATE_W'(2),
    LOAD   = STATE_W'(3),
    STORE  = STATE_W'(4),
    ADD    = STATE_W'(5),
    SUB    = STATE_W'(6),
    INPUT  = STATE_W'(7),
    INREL  = STATE_W'(8),
    JZ     = STATE_W'(9),
    JPOS   = STATE_W'(10),
    HALT   = STATE_W'(11)
  } state_t;

  state_t state;
  state_t next;

  logic [ENTER_SYNC-1:0] sync;
  logic                  enter_s;

  assign enter_s = sync[ENTER_SYNC-1];
  assign State   = state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync <= '0;
    end else begin
      sync[0] <= Enter;
      for (int i = 1; i < ENTER_SYNC; i++)
        sync[i] <= sync[i-1];
    end
  end

  // Reset forces START, whose decode is all-zero, so every
  // strobe (MemWr included) drops without waiting for a clock.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= START;
    else
      state <= next;
  end

  always_comb begin
    next    = START;
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = 2'b00;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    unique case (state)
      START: next = FETCH;
      FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
        next   = DECODE;
      end
      DECODE: begin
        Meminst = 1'b1;
        case (Opcode)
          3'b000:  next = LOAD;
          3'b001:  next = STORE;
          3'b010:  next = ADD;
          3'b011:  next = SUB;
          3'b100:  next = INPUT;
          3'b101:  next = JZ;
          3'b110:  next = JPOS;
          default: next = HALT;
        endcase
      end
      LOAD: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
        next    = FETCH;
      end
      STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
        next    = FETCH;
      end
      ADD: begin
        Meminst = 1'b1;
        Aload   = 1'b1;
        next    = FETCH;
      end
      SUB: begin
        Meminst = 1'b1;
        Sub     = 1'b1;
        Aload   = 1'b1;
        next    = FETCH;
      end
      INPUT: begin
        Asel  = 2'b01;
        Aload = enter_s;
        next  = enter_s ? INREL : INPUT;
      end
      // Wait for release so one press loads A exactly once.
      INREL: next = enter_s ? INREL : FETCH;
      JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
        next   = FETCH;
      end
      JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
        next   = FETCH;
      end
      HALT: begin
        Halt = 1'b1;
        next = HALT;
      end
      default: next = START;
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_control.sv
// Self-checking bench for fetch_exec_control.
// Instruction-level reference: each instruction is FETCH, DECODE, exec.
module tb_fetch_exec_control;

  localparam int SW = 4;
  localparam int ES = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic [2:0]    Opcode = 3'd0;
  logic          Aeq0 = 1'b0;
  logic          Apos = 1'b0;
  logic          Enter = 1'b0;
  logic          IRload, PCload, JMPmux, Meminst, MemWr;
  logic [1:0]    Asel;
  logic          Aload, Sub, Halt;
  logic [SW-1:0] State;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_exec_control #(.STATE_W(SW), .ENTER_SYNC(ES)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode),
    .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel),
    .Aload(Aload), .Sub(Sub), .Halt(Halt), .State(State)
  );

  always #5 Clock = ~Clock;

  // {IRload,PCload,JMPmux,Meminst,MemWr,Asel,Aload,Sub,Halt}
  logic [9:0] outs;
  assign outs = {IRload, PCload, JMPmux, Meminst, MemWr,
                 Asel, Aload, Sub, Halt};

  localparam logic [9:0] O_NONE   = 10'b0000000000;
  localparam logic [9:0] O_FETCH  = 10'b1100000000;
  localparam logic [9:0] O_DECODE = 10'b0001000000;
  localparam logic [9:0] O_LOAD   = 10'b0001010100;
  localparam logic [9:0] O_STORE  = 10'b0001100000;
  localparam logic [9:0] O_ADD    = 10'b0001000100;
  localparam logic [9:0] O_SUB    = 10'b0001000110;
  localparam logic [9:0] O_IN     = 10'b0000001000;
  localparam logic [9:0] O_INLD   = 10'b0000001100;
  localparam logic [9:0] O_HALT   = 10'b0000000001;

  // Instruction table: execute-cycle state and strobes per opcode.
  function automatic logic [13:0] exec_ref(
    input logic [2:0] op, input logic z, input logic p);
    case (op)
      3'd0:    return {4'd3, O_LOAD};
      3'd1:    return {4'd4, O_STORE};
      3'd2:    return {4'd5, O_ADD};
      3'd3:    return {4'd6, O_SUB};
      3'd4:    return {4'd7, O_IN};
      3'd5:    return {4'd9, 1'b0, z, 1'b1, 7'b0};
      3'd6:    return {4'd10, 1'b0, p, 1'b1, 7'b0};
      default: return {4'd11, O_HALT};
    endcase
  endfunction

  task automatic do_reset(input logic [2:0] op);
    Reset  = 1'b0;
    Opcode = op;
    Enter  = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Opcode = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      n_checks++;
      if (State !== 4'd0) begin
        n_fail++;
        $display("FAIL rst_state: got %0d want 0", State);
      end
      n_checks++;
      if (outs !== O_NONE) begin
        n_fail++;
        $display("FAIL rst_outs: got %b want %b", outs, O_NONE);
      end
    end
    Reset = 1'b1;
    #1;
    n_checks++;
    if (State !== 4'd0) begin
      n_fail++;
      $display("FAIL rel_start: got %0d want 0", State);
    end
    @(negedge Clock);
    n_checks++;
    if ({State, outs} !== {4'd1, O_FETCH}) begin
      n_fail++;
      $display("FAIL rel_fetch: got %0d/%b want 1/%b",
               State, outs, O_FETCH);
    end
    @(negedge Clock);
    n_checks++;
    if ({State, outs} !== {4'd2, O_DECODE}) begin
      n_fail++;
      $display("FAIL rel_decode: got %0d/%b want 2/%b",
               State, outs, O_DECODE);
    end
  endtask

  task automatic test_load();
    logic [13:0] seq [3];
    seq[0] = {4'd1, O_FETCH};
    seq[1] = {4'd2, O_DECODE};
    seq[2] = {4'd3, O_LOAD};
    do_reset(3'd0);
    for (int k = 0; k < 9; k++) begin
      @(negedge Clock);
      n_checks++;
      if ({State, outs} !== seq[k % 3]) begin
        n_fail++;
        $display("FAIL load_seq[%0d]: got %0d/%b want %0d/%b", k,
                 State, outs, seq[k%3][13:10], seq[k%3][9:0]);
      end
    end
  endtask

  task automatic test_store();
    logic [13:0] seq [3];
    int wr = 0;
    seq[0] = {4'd1, O_FETCH};
    seq[1] = {4'd2, O_DECODE};
    seq[2] = {4'd4, O_STORE};
    do_reset(3'd1);
    for (int k = 0; k < 9; k++) begin
      @(negedge Clock);
      if (MemWr === 1'b1) wr++;
      n_checks++;
      if ({State, outs} !== seq[k % 3]) begin
        n_fail++;
        $display("FAIL store_seq[%0d]: got %0d/%b want %0d/%b", k,
                 State, outs, seq[k%3][13:10], seq[k%3][9:0]);
      end
    end
    n_checks++;
    if (wr != 3) begin
      n_fail++;
      $display("FAIL store_wr_cnt: got %0d want 3", wr);
    end
    // Now mid-STORE: pull reset and look before the next edge.
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if ({State, MemWr} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL store_async_rst: got st=%0d wr=%b want 0/0",
               State, MemWr);
    end
  endtask

  task automatic test_jump();
    logic [2:0]  op;
    logic        f;
    logic [13:0] e;
    for (int a = 0; a < 4; a++) begin
      op = (a < 2) ? 3'd5 : 3'd6;
      f  = (a % 2 == 0);
      do_reset(op);
      Aeq0 = (op == 3'd5) ? f : ~f;
      Apos = (op == 3'd6) ? f : ~f;
      repeat (3) @(negedge Clock);
      e = exec_ref(op, Aeq0, Apos);
      n_checks++;
      if ({State, outs} !== e) begin
        n_fail++;
        $display("FAIL jump op%0d f%0d: got %0d/%b want %0d/%b",
                 op, f, State, outs, e[13:10], e[9:0]);
      end
      if (op == 3'd5) Aeq0 = ~Aeq0;
      else            Apos = ~Apos;
      #1;
      n_checks++;
      if (PCload !== ~f) begin
        n_fail++;
        $display("FAIL jump_comb op%0d: got %b want %b",
                 op, PCload, ~f);
      end
    end
  endtask

  task automatic test_input();
    int   phase = 0;
    int   pulses = 0;
    int   pulse_at = -99;
    logic es;
    logic [13:0] e;
    do_reset(3'd4);
    repeat (2) @(negedge Clock);
    for (int j = -5; j < 16 && phase < 3; j++) begin
      @(negedge Clock);
      Enter = (j >= 0 && j < 4);
      // Synchronised Enter lags the pin by ES clocks.
      es = (j - ES >= 0 && j - ES < 4);
      if (Aload === 1'b1) begin
        pulses++;
        pulse_at = j;
      end
      case (phase)
        0: begin
          e = {4'd7, es ? O_INLD : O_IN};
          if (es) phase = 1;
        end
        1: begin
          e = {4'd8, O_NONE};
          if (!es) phase = 2;
        end
        default: begin
          e = {4'd1, O_FETCH};
          phase = 3;
        end
      endcase
      n_checks++;
      if ({State, outs} !== e) begin
        n_fail++;
        $display("FAIL input j=%0d: got %0d/%b want %0d/%b", j,
                 State, outs, e[13:10], e[9:0]);
      end
    end
    n_checks++;
    if (phase != 3) begin
      n_fail++;
      $display("FAIL input_end: got phase %0d want 3", phase);
    end
    n_checks++;
    if (pulses != 1 || pulse_at != ES) begin
      n_fail++;
      $display("FAIL input_aload: got %0d@%0d want 1@%0d",
               pulses, pulse_at, ES);
    end
  endtask

  task automatic test_halt();
    logic [13:0] seq [3];
    seq[0] = {4'd1, O_FETCH};
    seq[1] = {4'd2, O_DECODE};
    seq[2] = {4'd11, O_HALT};
    do_reset(3'd7);
    for (int k = 0; k < 23; k++) begin
      @(negedge Clock);
      Enter = 1'($urandom);
      n_checks++;
      if ({State, outs} !== seq[(k > 2) ? 2 : k]) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %0d/%b", k, State, outs);
      end
    end
    Reset = 1'b0;
    #1;
    n_checks++;
    if ({State, Halt} !== {4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_rst: got st=%0d halt=%b want 0/0",
               State, Halt);
    end
    Enter = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [13:0] e;
    do_reset(3'd0);
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 5));
      if (op >= 3'd4) op = op + 3'd1;
      @(negedge Clock);
      Opcode = op;
      Aeq0 = 1'($urandom);
      Apos = 1'($urandom);
      n_checks++;
      if ({State, outs} !== {4'd1, O_FETCH}) begin
        n_fail++;
        $display("FAIL rnd_fetch[%0d]: got %0d/%b", n, State, outs);
      end
      @(negedge Clock);
      n_checks++;
      if ({State, outs} !== {4'd2, O_DECODE}) begin
        n_fail++;
        $display("FAIL rnd_decode[%0d]: got %0d/%b", n, State, outs);
      end
      @(negedge Clock);
      e = exec_ref(op, Aeq0, Apos);
      n_checks++;
      if ({State, outs} !== e) begin
        n_fail++;
        $display("FAIL rnd_exec[%0d] op%0d: got %0d/%b want %0d/%b",
                 n, op, State, outs, e[13:10], e[9:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_jump();
    test_input();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
